// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: sequences LSU load/store accesses onto the shared data-memory
// bus. One access in flight at a time; misaligned/illegal requests and bus
// timeouts complete with resp_err instead of stalling the pipeline.
//
// Ports:
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      core request handshake
//   req_we, req_addr, req_wdata, req_size, req_unsigned   request fields
//   resp_valid/rdata/err     one-cycle completion pulse with formatted data
//   busy                     controller not in IDLE
//   mem_req/we/addr/be/wdata memory request side
//   mem_gnt, mem_rvalid, mem_rdata   memory grant / read data / write ack

// Per-byte-lane store formatting: byte enable and the byte placed on this lane.
module lsu_store_lane #(
    parameter int LANE = 0
) (
    input  logic [1:0] size,
    input  logic [1:0] off,
    input  logic [7:0] b0,     // wdata[7:0]
    input  logic [7:0] b1,     // wdata[15:8]
    input  logic [7:0] bl,     // wdata byte matching this lane
    output logic       be,
    output logic [7:0] wbyte
);
    localparam logic [1:0] LIDX = 2'(LANE);

    always_comb begin
        be    = 1'b0;
        wbyte = 8'h00;
        case (size)
            2'b00: begin
                be    = (off == LIDX);
                wbyte = b0;
            end
            2'b01: begin
                // halves are 2-byte aligned, so only off[1] selects the pair
                be    = (off[1] == LIDX[1]);
                wbyte = LIDX[0] ? b1 : b0;
            end
            2'b10: begin
                be    = 1'b1;
                wbyte = bl;
            end
            default: ;
        endcase
    end
endmodule

module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);
    localparam int NUM_LANES = 4;
    localparam int CNT_W     = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
    state_t state, state_nxt;

    logic [CNT_W-1:0] tmo_cnt;
    logic             lat_we, lat_uns;
    logic [1:0]       lat_size, lat_off;

    logic                            misaligned, done, tmo;
    logic [NUM_LANES-1:0]            lane_be;
    logic [NUM_LANES-1:0][7:0]       lane_wdata;
    logic [31:0]                     rd_shift, rd_fmt;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    assign misaligned = (req_size == 2'b11)
                      | ((req_size == 2'b01) & req_addr[0])
                      | ((req_size == 2'b10) & (|req_addr[1:0]));

    // mem_rvalid only counts alongside mem_gnt in REQ (zero-wait memory)
    assign done = ((state == REQ) & mem_gnt & mem_rvalid)
                | ((state == WAIT) & mem_rvalid);
    assign tmo  = ((state == REQ) | (state == WAIT)) & (tmo_cnt == CNT_LAST) & ~done;

    genvar g;
    generate
        for (g = 0; g < NUM_LANES; g++) begin : g_lane
            lsu_store_lane #(.LANE(g)) u_lane (
                .size  (req_size),
                .off   (req_addr[1:0]),
                .b0    (req_wdata[7:0]),
                .b1    (req_wdata[15:8]),
                .bl    (req_wdata[8*g +: 8]),
                .be    (lane_be[g]),
                .wbyte (lane_wdata[g])
            );
        end
    endgenerate

    always_comb begin
        rd_shift = mem_rdata >> {lat_off, 3'b000};
        rd_fmt   = rd_shift;
        case (lat_size)
            2'b00:   rd_fmt = lat_uns ? {24'h0, rd_shift[7:0]}
                                      : {{24{rd_shift[7]}}, rd_shift[7:0]};
            2'b01:   rd_fmt = lat_uns ? {16'h0, rd_shift[15:0]}
                                      : {{16{rd_shift[15]}}, rd_shift[15:0]};
            default: rd_fmt = rd_shift;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (req_valid) state_nxt = misaligned ? RESP : REQ;
            REQ: begin
                if (done || tmo)  state_nxt = RESP;
                else if (mem_gnt) state_nxt = WAIT;
            end
            WAIT: if (done || tmo) state_nxt = RESP;
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_cnt    <= '0;
            lat_we     <= 1'b0;
            lat_uns    <= 1'b0;
            lat_size   <= 2'b00;
            lat_off    <= 2'b00;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_be     <= '0;
            mem_wdata  <= '0;
        end else begin
            // response fields live for the single RESP cycle only
            resp_valid <= (state_nxt == RESP);
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_we   <= req_we;
                        lat_uns  <= req_unsigned;
                        lat_size <= req_size;
                        lat_off  <= req_addr[1:0];
                        tmo_cnt  <= '0;
                        if (misaligned) begin
                            resp_err <= 1'b1;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= req_we;
                            mem_addr  <= {req_addr[31:2], 2'b00};
                            mem_be    <= lane_be;
                            mem_wdata <= lane_wdata;
                        end
                    end
                end
                REQ, WAIT: begin
                    tmo_cnt <= tmo_cnt + 1'b1;
                    if (mem_gnt || tmo) mem_req <= 1'b0;
                    if (done)     resp_rdata <= lat_we ? 32'h0 : rd_fmt;
                    else if (tmo) resp_err   <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
